board_io_conditioner: RTL
=========================

// Module: board_io_conditioner
// PURPOSE
//   Board-side I/O front end between the DE10 pins and the pipelined core. Synchronises and
//   debounces N_SW switches and N_KEY push-buttons, normalises key polarity to active-high,
//   emits one-cycle press/release/change pulses, packs the levels into the core's 32-bit
//   switch word, and stretches the core's instruction-valid pulse into a visible LED level.
// PARAMETERS
//   N_SW            10        switch channels; N_SW+N_KEY <= 32
//   N_KEY           4         key channels
//   KEY_ACTIVE_LOW  1         1: raw key 0 = pressed (inverted internally); 0: raw 1 = pressed
//   SYNC_STAGES     2         synchroniser flops per channel, >= 2
//   DEBOUNCE_CYCLES 250000    consecutive stable cycles needed to accept a change, >= 1
//   STRETCH_CYCLES  2500000   o_activity hold time in cycles, >= 1
// PORTS
//   i_clk          in   1            system clock (divided core clock)
//   i_reset        in   1            asynchronous, active-high reset
//   i_sw           in   N_SW         raw switch pins, 1 = ON
//   i_key          in   N_KEY        raw key pins, polarity per KEY_ACTIVE_LOW
//   i_activity     in   1            core insn-valid pulse
//   o_sw           out  N_SW         debounced switch levels
//   o_key          out  N_KEY        debounced key levels, 1 = pressed
//   o_key_press    out  N_KEY        one-cycle pulse on o_key 0->1
//   o_key_release  out  N_KEY        one-cycle pulse on o_key 1->0
//   o_sw_change    out  N_SW         one-cycle pulse on any o_sw transition
//   o_io_word      out  32           {zeros, o_key, o_sw} -> core i_io_sw
//   o_activity     out  1            stretched activity level for LEDR[9]
// BEHAVIOUR
//   - Reset: all outputs 0; sync chains, debounce counters, stretch counter cleared; sync
//     chains load released value (post-polarity 0). Reset mid-count discards progress.
//   - Sync: raw (after key inversion) passes SYNC_STAGES flops -> s[i]. No other use of raw.
//   - Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES+1), states STABLE/COUNTING:
//     s==d: cnt<=0 (STABLE). s!=d and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1 (COUNTING).
//     s!=d and cnt==DEBOUNCE_CYCLES-1: d<=s, cnt<=0, edge pulse registered same edge.
//     Any return of s to d before terminal count clears cnt (bounce rejected).
//   - Latency: level change on raw pin to o_* change = SYNC_STAGES+DEBOUNCE_CYCLES rising
//     edges (edge sampling the change counts as 1). Pulses coincide with the level change,
//     exactly one cycle wide; channels independent; simultaneous changes all pulse together.
//   - o_io_word: combinational pack of registered o_sw (bits N_SW-1:0) and o_key (next
//     N_KEY bits); remaining bits constant 0.
//   - Stretch: i_activity sampled high loads counter with STRETCH_CYCLES; else decrements
//     to 0. o_activity registered = (counter load or counter>1), i.e. high exactly
//     STRETCH_CYCLES cycles starting the cycle after the last i_activity-high cycle;
//     re-trigger while high restarts the full window; continuous activity keeps it high.
// CONFIGURATION
//   BOARD_IO_ACTIVITY_STRETCH_EN defined: stretcher as above.
//   Not defined: no stretch counter; o_activity = i_activity delayed one register
//   (reset 0); STRETCH_CYCLES ignored. All other behaviour identical.
// TESTING  (N_SW=10, N_KEY=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8)
//   1 Assert i_reset async mid-cycle, i_key=4'hF, i_sw=0 -> all outputs 0 immediately, o_io_word=0.
//   2 i_key[0] 1->0 held -> o_key[0]=1 and o_key_press[0] 1-cycle pulse on 6th edge;
//     o_io_word=32'h0000_0400.
//   3 i_key[1] low for 3 cycles then high (bounce) -> o_key[1] stays 0, no pulses.
//   4 i_sw=10'h001 held, then key0 released -> o_sw_change[0] pulse, o_io_word[0]=1;
//     o_key_release[0] pulse 6 edges after release, o_io_word=32'h0000_0001.
//   5 Macro on: 1-cycle i_activity -> o_activity high 8 cycles; second pulse 5 cycles later
//     -> high 13 cycles total. Macro off: high 1 cycle, 1 cycle after input.
//   6 Reset asserted at cnt=2 of a pending switch change, released -> change accepted only
//     after full 6-edge latency from reset release; no spurious pulse at reset release.

Source files
------------

// File: rtl/board_io_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : board_io_conditioner
//  Purpose  : Board-side I/O front end between the DE10 pins and the core.
//             Synchronises and debounces switches and push-buttons, turns
//             key polarity into active-high, produces one-cycle press /
//             release / change pulses, packs the debounced levels into the
//             core's 32-bit switch word and stretches the core's
//             instruction-valid pulse into an LED-visible level.
//  Ports    : i_clk         system clock (divided core clock)
//             i_reset       asynchronous active-high reset
//             i_sw          raw switch pins, 1 = ON
//             i_key         raw key pins, polarity set by KEY_ACTIVE_LOW
//             i_activity    core instruction-valid pulse
//             o_sw          debounced switch levels
//             o_key         debounced key levels, 1 = pressed
//             o_key_press   one-cycle pulse on o_key 0->1
//             o_key_release one-cycle pulse on o_key 1->0
//             o_sw_change   one-cycle pulse on any o_sw transition
//             o_io_word     {zeros, o_key, o_sw}
//             o_activity    stretched activity level (LEDR[9])
//  Macro    : BOARD_IO_ACTIVITY_STRETCH_EN
//             defined     -> o_activity held STRETCH_CYCLES cycles per pulse
//             not defined -> o_activity is i_activity delayed one register
//  Revision : 1.0  initial release
// ============================================================================
module board_io_conditioner #(
  parameter int N_SW            = 10,
  parameter int N_KEY           = 4,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STRETCH_CYCLES  = 2500000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_SW-1:0]   i_sw,
  input  logic [N_KEY-1:0]  i_key,
  input  logic              i_activity,
  output logic [N_SW-1:0]   o_sw,
  output logic [N_KEY-1:0]  o_key,
  output logic [N_KEY-1:0]  o_key_press,
  output logic [N_KEY-1:0]  o_key_release,
  output logic [N_SW-1:0]   o_sw_change,
  output logic [31:0]       o_io_word,
  output logic              o_activity
);

  // Switches occupy the low channel indices, keys the ones above them; this
  // matches the bit order of o_io_word.
  localparam int N_CH = N_SW + N_KEY;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_TERM = DB_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time guard on the legal parameter ranges.
  if ((N_CH > 32) || (N_SW < 1) || (N_KEY < 1) || (SYNC_STAGES < 2) ||
      (DEBOUNCE_CYCLES < 1) || (STRETCH_CYCLES < 1)) begin : g_bad_params
    $error("board_io_conditioner: illegal parameter combination");
  end

  // --------------------------------------------------------------------------
  // Key polarity: everything downstream sees 1 = pressed.
  // --------------------------------------------------------------------------
  logic [N_KEY-1:0] key_lvl;

  if (KEY_ACTIVE_LOW != 0) begin : g_key_inv
    assign key_lvl = ~i_key;
  end else begin : g_key_pass
    assign key_lvl = i_key;
  end

  logic [N_CH-1:0] raw_lvl;
  assign raw_lvl = {key_lvl, i_sw};

  // --------------------------------------------------------------------------
  // Synchroniser chains. Reset loads the released value (0) so that a held
  // key does not look like a fresh press at reset release beyond the normal
  // debounce latency.
  // --------------------------------------------------------------------------
  logic [N_CH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= raw_lvl;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  logic [N_CH-1:0] sync_lvl;
  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Per-channel debounce. A zero count is the STABLE condition; a non-zero
  // count means a differing synchronised level is being timed (COUNTING).
  // Any cycle where the input agrees with the accepted level clears the
  // count, so a bounce never accumulates toward acceptance.
  // --------------------------------------------------------------------------
  logic [N_CH-1:0] lvl_vec;
  logic [N_CH-1:0] rise_vec;
  logic [N_CH-1:0] fall_vec;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            lvl_q, lvl_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    always_comb begin
      cnt_d  = '0;
      lvl_d  = lvl_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync_lvl[c] != lvl_q) begin
        if (cnt_q == DB_TERM) begin
          // Accept the new level; the pulse is registered on the same edge
          // so it lines up with the level change at the outputs.
          lvl_d  = sync_lvl[c];
          rise_d = sync_lvl[c];
          fall_d = ~sync_lvl[c];
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        lvl_q  <= lvl_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign lvl_vec[c]  = lvl_q;
    assign rise_vec[c] = rise_q;
    assign fall_vec[c] = fall_q;
  end

  assign o_sw          = lvl_vec[N_SW-1:0];
  assign o_key         = lvl_vec[N_CH-1:N_SW];
  assign o_key_press   = rise_vec[N_CH-1:N_SW];
  assign o_key_release = fall_vec[N_CH-1:N_SW];
  assign o_sw_change   = rise_vec[N_SW-1:0] | fall_vec[N_SW-1:0];

  // --------------------------------------------------------------------------
  // Core switch word.
  // --------------------------------------------------------------------------
  if (N_CH < 32) begin : g_io_pad
    assign o_io_word = {{(32 - N_CH){1'b0}}, lvl_vec};
  end else begin : g_io_full
    assign o_io_word = lvl_vec;
  end

  // --------------------------------------------------------------------------
  // Activity indicator.
  // --------------------------------------------------------------------------
  logic act_q, act_d;

`ifdef BOARD_IO_ACTIVITY_STRETCH_EN
  localparam int ST_W = $clog2(STRETCH_CYCLES + 1);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STRETCH_CYCLES);

  logic [ST_W-1:0] st_cnt_q, st_cnt_d;

  // The load value is STRETCH_CYCLES and the output looks at the count
  // before it decrements, so "count > 1" yields exactly STRETCH_CYCLES high
  // cycles after the last sampled activity.
  always_comb begin
    st_cnt_d = st_cnt_q;
    act_d    = 1'b0;
    if (i_activity) begin
      st_cnt_d = ST_LOAD;
      act_d    = 1'b1;
    end else begin
      if (st_cnt_q != '0) begin
        st_cnt_d = st_cnt_q - ST_W'(1);
      end
      act_d = (st_cnt_q > ST_W'(1));
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      st_cnt_q <= '0;
    end else begin
      st_cnt_q <= st_cnt_d;
    end
  end
`else
  always_comb begin
    act_d = i_activity;
  end
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      act_q <= 1'b0;
    end else begin
      act_q <= act_d;
    end
  end

  assign o_activity = act_q;

endmodule
`default_nettype wire
